// File: rtl/holy_axi_bus_arbiter_if.sv
// Arbiter-side bundle: cache requests/grants plus the muxed AXI handshakes it monitors.
// master = arbiter, slave = cache pair / AXI mux side.
interface holy_axi_bus_arbiter_if #(
   parameter int BEAT_W = 8
);
   logic              i_req, d_req;
   logic              i_grant, d_grant, owner, busy;
   logic              m_axi_arvalid, m_axi_arready;
   logic [BEAT_W-1:0] m_axi_arlen;
   logic              m_axi_awvalid, m_axi_awready;
   logic [BEAT_W-1:0] m_axi_awlen;
   logic              m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic              m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic              m_axi_bvalid, m_axi_bready;
   logic [BEAT_W-1:0] beat_cnt;
   logic              burst_err;

   modport master (
      input  i_req, d_req,
      input  m_axi_arvalid, m_axi_arready, m_axi_arlen,
      input  m_axi_awvalid, m_axi_awready, m_axi_awlen,
      input  m_axi_wvalid, m_axi_wready, m_axi_wlast,
      input  m_axi_rvalid, m_axi_rready, m_axi_rlast,
      input  m_axi_bvalid, m_axi_bready,
      output i_grant, d_grant, owner, busy, beat_cnt, burst_err
   );

   modport slave (
      output i_req, d_req,
      output m_axi_arvalid, m_axi_arready, m_axi_arlen,
      output m_axi_awvalid, m_axi_awready, m_axi_awlen,
      output m_axi_wvalid, m_axi_wready, m_axi_wlast,
      output m_axi_rvalid, m_axi_rready, m_axi_rlast,
      output m_axi_bvalid, m_axi_bready,
      input  i_grant, d_grant, owner, busy, beat_cnt, burst_err
   );
endinterface

// File: rtl/holy_axi_bus_arbiter.sv
// Whole-transaction i-cache/d-cache arbiter for the shared AXI4 master port.
// Optional stall watchdog: define HOLY_ARB_WATCHDOG_EN.
module holy_axi_bus_arbiter #(
   parameter bit D_PRIORITY  = 1'b1,
   parameter int BEAT_W      = 8,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   holy_axi_bus_arbiter_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]        state;
   logic              owner_q, last_served, dir_wr, wlast_seen, err_q;
   logic [BEAT_W-1:0] exp_len, beat_q, beat_inc;
   logic              ar_hs, aw_hs, w_hs, r_hs, b_hs;
   logic              own_req, in_flight, wdog_hit;

   assign ar_hs     = bus.m_axi_arvalid && bus.m_axi_arready;
   assign aw_hs     = bus.m_axi_awvalid && bus.m_axi_awready;
   assign w_hs      = bus.m_axi_wvalid  && bus.m_axi_wready;
   assign r_hs      = bus.m_axi_rvalid  && bus.m_axi_rready;
   assign b_hs      = bus.m_axi_bvalid  && bus.m_axi_bready;
   assign own_req   = owner_q ? bus.d_req : bus.i_req;
   assign in_flight = (state == S_ADDR) || (state == S_DATA);
   assign beat_inc  = (beat_q == '1) ? beat_q : beat_q + BEAT_W'(1);

   assign bus.i_grant   = in_flight && !owner_q;
   assign bus.d_grant   = in_flight &&  owner_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = in_flight;
   assign bus.beat_cnt  = beat_q;
   assign bus.burst_err = err_q;

`ifdef HOLY_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0] wdog;
   logic            progress;

   assign progress = ((state == S_ADDR) && (ar_hs || aw_hs)) ||
                     ((state == S_DATA) && (dir_wr ? (w_hs || b_hs) : r_hs));
   assign wdog_hit = in_flight && (wdog == WD_W'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              wdog <= '0;
      else if (!in_flight || progress || wdog_hit) wdog <= '0;
      else                                     wdog <= wdog + WD_W'(1);
   end
`else
   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         owner_q     <= 1'b0;
         last_served <= ~D_PRIORITY;
         dir_wr      <= 1'b0;
         wlast_seen  <= 1'b0;
         exp_len     <= '0;
         beat_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.i_req || bus.d_req) begin
               // Contention goes to whoever was not served last
               owner_q <= (bus.i_req && bus.d_req) ? ~last_served : bus.d_req;
               state   <= S_ADDR;
            end
            S_ADDR: begin
               if (wdog_hit) begin
                  err_q <= 1'b1;
                  state <= S_GAP;
               end else if (ar_hs) begin
                  exp_len    <= bus.m_axi_arlen;
                  dir_wr     <= 1'b0;
                  wlast_seen <= 1'b0;
                  state      <= S_DATA;
                  if (aw_hs) err_q <= 1'b1;
               end else if (aw_hs) begin
                  exp_len    <= bus.m_axi_awlen;
                  dir_wr     <= 1'b1;
                  wlast_seen <= 1'b0;
                  state      <= S_DATA;
               end else if (!own_req) begin
                  state <= S_IDLE;
               end
            end
            S_DATA: begin
               if (wdog_hit) begin
                  err_q <= 1'b1;
                  state <= S_GAP;
               end else if (!dir_wr) begin
                  if (r_hs) begin
                     beat_q <= beat_inc;
                     if (bus.m_axi_rlast) begin
                        state <= S_GAP;
                        if (beat_q != exp_len) err_q <= 1'b1;
                     end else if (beat_q == exp_len) begin
                        err_q <= 1'b1;   // overran arlen; keep waiting for rlast
                     end
                  end
               end else begin
                  if (w_hs && !wlast_seen) begin
                     beat_q <= beat_inc;
                     if (bus.m_axi_wlast) begin
                        wlast_seen <= 1'b1;
                        if (beat_q != exp_len) err_q <= 1'b1;
                     end
                  end
                  if (b_hs && (wlast_seen || (w_hs && bus.m_axi_wlast)))
                     state <= S_GAP;
               end
            end
            default: begin
               // GAP: beat_cnt stays readable for this cycle, cleared on exit
               last_served <= owner_q;
               beat_q      <= '0;
               state       <= S_IDLE;
            end
         endcase
      end
   end
endmodule
